// File: rtl/mem_lsu.sv
// Memory stage between execute and writeback: one-cycle pipeline register for ALU results,
// plus a req/ack transaction against a variable-latency DMEM with byte lanes and a timeout abort.
module mem_lsu #(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned DMEM_WORD_WIDTH = 16,
  parameter int unsigned IALU_WORD_WIDTH = 16,
  parameter int unsigned PMEM_WORD_WIDTH = 16,
  parameter int unsigned REG_IDX_WIDTH   = 4,
  parameter int unsigned DMEM_TIMEOUT    = 15,
  localparam int unsigned NB     = DMEM_WORD_WIDTH / 8,
  localparam int unsigned BSEL_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       out_ready,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic                       in_size_byte,
  input  logic                       in_sign_ext,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_addr,
  input  logic [BSEL_W-1:0]          in_byte_sel,
  input  logic [DMEM_WORD_WIDTH-1:0] in_wr_word,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  output logic                       out_mem_req,
  output logic                       out_mem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic [NB-1:0]              out_mem_byte_en,
  input  logic                       in_mem_ack,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word,
  output logic                       out_valid,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic                       out_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic                       req_q, req_d;
  logic                       we_q, we_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DMEM_WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]              ben_q, ben_d;
  logic                       cap_byte_q, cap_byte_d;
  logic                       cap_sign_q, cap_sign_d;
  logic [BSEL_W-1:0]          cap_sel_q, cap_sel_d;
  logic                       cap_wr_q, cap_wr_d;
  logic [REG_IDX_WIDTH-1:0]   cap_idx_q, cap_idx_d;
  logic [PMEM_WORD_WIDTH-1:0] cap_instr_q, cap_instr_d;
  logic                       valid_q, valid_d;
  logic                       wr_q, wr_d;
  logic                       err_q, err_d;
  logic [IALU_WORD_WIDTH-1:0] res_q, res_d;
  logic [REG_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [PMEM_WORD_WIDTH-1:0] instr_q, instr_d;

  logic [DMEM_WORD_WIDTH-1:0] rd_shift;
  logic [7:0]                 rd_lane;
  logic [IALU_WORD_WIDTH-1:0] load_data;
  logic [7:0]                 cnt_inc;

  // Lane select and sign/zero extension of the read word
  assign rd_shift  = in_mem_rd_word >> {cap_sel_q, 3'b000};
  assign rd_lane   = rd_shift[7:0];
  assign load_data = cap_byte_q ? {{(IALU_WORD_WIDTH-8){rd_lane[7] & cap_sign_q}}, rd_lane}
                                : IALU_WORD_WIDTH'(in_mem_rd_word);
  assign cnt_inc   = 8'(cnt_q + 8'd1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ben_d       = ben_q;
    cap_byte_d  = cap_byte_q;
    cap_sign_d  = cap_sign_q;
    cap_sel_d   = cap_sel_q;
    cap_wr_d    = cap_wr_q;
    cap_idx_d   = cap_idx_q;
    cap_instr_d = cap_instr_q;
    valid_d     = 1'b0;
    wr_d        = 1'b0;
    err_d       = 1'b0;
    res_d       = res_q;
    idx_d       = idx_q;
    instr_d     = instr_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_act_load_dmem && in_act_store_dmem) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            res_d   = in_res;
            idx_d   = in_res_reg_idx;
            instr_d = in_instr;
          end else if (in_act_load_dmem || in_act_store_dmem) begin
            state_d     = WAIT;
            cnt_d       = 8'd0;
            req_d       = 1'b1;
            we_d        = in_act_store_dmem;
            addr_d      = in_addr;
            wdata_d     = in_size_byte ? {NB{in_wr_word[7:0]}} : in_wr_word;
            ben_d       = (in_size_byte && in_act_store_dmem) ? (NB'(1) << in_byte_sel) : '1;
            cap_byte_d  = in_size_byte;
            cap_sign_d  = in_sign_ext;
            cap_sel_d   = in_byte_sel;
            cap_wr_d    = in_act_write_res_to_reg;
            cap_idx_d   = in_res_reg_idx;
            cap_instr_d = in_instr;
          end else begin
            valid_d = 1'b1;
            wr_d    = in_act_write_res_to_reg;
            res_d   = in_res;
            idx_d   = in_res_reg_idx;
            instr_d = in_instr;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over a coincident timeout
        if (in_mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          idx_d   = cap_idx_q;
          instr_d = cap_instr_q;
          if (we_q) begin
            res_d = '0;
          end else begin
            res_d = load_data;
            wr_d  = cap_wr_q;
          end
        end else if (cnt_inc == 8'(DMEM_TIMEOUT)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          err_d   = 1'b1;
          idx_d   = cap_idx_q;
          instr_d = cap_instr_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ben_q       <= '0;
      cap_byte_q  <= 1'b0;
      cap_sign_q  <= 1'b0;
      cap_sel_q   <= '0;
      cap_wr_q    <= 1'b0;
      cap_idx_q   <= '0;
      cap_instr_q <= '0;
      valid_q     <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      res_q       <= '0;
      idx_q       <= '0;
      instr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ben_q       <= ben_d;
      cap_byte_q  <= cap_byte_d;
      cap_sign_q  <= cap_sign_d;
      cap_sel_q   <= cap_sel_d;
      cap_wr_q    <= cap_wr_d;
      cap_idx_q   <= cap_idx_d;
      cap_instr_q <= cap_instr_d;
      valid_q     <= valid_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      instr_q     <= instr_d;
    end
  end

  assign out_ready                = (state_q == IDLE);
  assign out_mem_req              = req_q;
  assign out_mem_we               = we_q;
  assign out_mem_addr             = addr_q;
  assign out_mem_wr_word          = wdata_q;
  assign out_mem_byte_en          = ben_q;
  assign out_valid                = valid_q;
  assign out_act_write_res_to_reg = wr_q;
  assign out_err                  = err_q;
  assign out_res                  = res_q;
  assign out_res_reg_idx          = idx_q;
  assign out_instr                = instr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: vector table for single operations plus timeout and reset sequences.
module tb_mem_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
  logic        in_size_byte, in_sign_ext;
  logic [11:0] in_addr;
  logic [0:0]  in_byte_sel;
  logic [15:0] in_wr_word, in_res, in_instr;
  logic [3:0]  in_res_reg_idx;
  logic        out_mem_req, out_mem_we;
  logic [11:0] out_mem_addr;
  logic [15:0] out_mem_wr_word;
  logic [1:0]  out_mem_byte_en;
  logic        in_mem_ack;
  logic [15:0] in_mem_rd_word;
  logic        out_valid, out_act_write_res_to_reg, out_err;
  logic [15:0] out_res, out_instr;
  logic [3:0]  out_res_reg_idx;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .out_ready(out_ready),
    .in_act_load_dmem(in_act_load_dmem), .in_act_store_dmem(in_act_store_dmem),
    .in_act_write_res_to_reg(in_act_write_res_to_reg),
    .in_size_byte(in_size_byte), .in_sign_ext(in_sign_ext),
    .in_addr(in_addr), .in_byte_sel(in_byte_sel), .in_wr_word(in_wr_word),
    .in_res(in_res), .in_res_reg_idx(in_res_reg_idx), .in_instr(in_instr),
    .out_mem_req(out_mem_req), .out_mem_we(out_mem_we), .out_mem_addr(out_mem_addr),
    .out_mem_wr_word(out_mem_wr_word), .out_mem_byte_en(out_mem_byte_en),
    .in_mem_ack(in_mem_ack), .in_mem_rd_word(in_mem_rd_word),
    .out_valid(out_valid), .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_res(out_res), .out_res_reg_idx(out_res_reg_idx), .out_instr(out_instr),
    .out_err(out_err)
  );

  typedef struct {
    logic        load, store, wr, byte_sz, sign;
    logic        sel;
    logic [11:0] addr;
    logic [15:0] wdata, res;
    logic [3:0]  idx;
    int          k;
    logic [15:0] rd;
    logic [15:0] e_res;
    logic        e_wr, e_err;
    logic [1:0]  e_ben;
    logic [15:0] e_wdata;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ld, input logic st, input logic wr, input logic bs,
                              input logic sg, input logic sl, input logic [11:0] ad,
                              input logic [15:0] wd, input logic [15:0] rs, input logic [3:0] ix,
                              input int k, input logic [15:0] rd, input logic [15:0] er,
                              input logic ew, input logic ee, input logic [1:0] eb,
                              input logic [15:0] ewd);
    vec_t v;
    v.load = ld; v.store = st; v.wr = wr; v.byte_sz = bs; v.sign = sg; v.sel = sl;
    v.addr = ad; v.wdata = wd; v.res = rs; v.idx = ix; v.k = k; v.rd = rd;
    v.e_res = er; v.e_wr = ew; v.e_err = ee; v.e_ben = eb; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_act_load_dmem = 1'b0; in_act_store_dmem = 1'b0;
    in_act_write_res_to_reg = 1'b0; in_size_byte = 1'b0; in_sign_ext = 1'b0;
    in_addr = '0; in_byte_sel = '0; in_wr_word = '0; in_res = '0;
    in_res_reg_idx = '0; in_instr = '0;
  endtask

  initial begin
    vec_t v;
    //           ld st wr bs sg sl addr     wdata     res       idx  k   rd        e_res     ew ee ben    e_wdata
    vecs[0]  = mk(0, 0, 1, 0, 0, 0, 12'h000, 16'h0000, 16'h1234, 4'd3, 0, 16'h0000, 16'h1234, 1, 0, 2'b11, 16'h0000);
    vecs[1]  = mk(0, 0, 1, 0, 0, 0, 12'h000, 16'h0000, 16'h5678, 4'd4, 0, 16'h0000, 16'h5678, 1, 0, 2'b11, 16'h0000);
    vecs[2]  = mk(0, 1, 1, 0, 0, 0, 12'h010, 16'hBEEF, 16'h1111, 4'd6, 3, 16'h0000, 16'h0000, 0, 0, 2'b11, 16'hBEEF);
    vecs[3]  = mk(1, 0, 1, 1, 1, 1, 12'h020, 16'h0000, 16'h2222, 4'd5, 1, 16'h80F0, 16'hFF80, 1, 0, 2'b11, 16'h0000);
    vecs[4]  = mk(1, 0, 1, 1, 0, 0, 12'h020, 16'h0000, 16'h0000, 4'd7, 1, 16'h80F0, 16'h00F0, 1, 0, 2'b11, 16'h0000);
    vecs[5]  = mk(0, 1, 0, 1, 0, 1, 12'h030, 16'h00AB, 16'h0000, 4'd2, 2, 16'h0000, 16'h0000, 0, 0, 2'b10, 16'hABAB);
    vecs[6]  = mk(1, 0, 1, 0, 0, 0, 12'hFFF, 16'h0000, 16'h0000, 4'd9, 4, 16'h1357, 16'h1357, 1, 0, 2'b11, 16'h0000);
    vecs[7]  = mk(1, 0, 1, 1, 1, 1, 12'h001, 16'h0000, 16'h0000, 4'd8, 2, 16'h7F00, 16'h007F, 1, 0, 2'b11, 16'h0000);
    vecs[8]  = mk(1, 1, 1, 0, 0, 0, 12'h040, 16'h0000, 16'h3333, 4'd1, 0, 16'h0000, 16'h0000, 0, 1, 2'b11, 16'h0000);
    vecs[9]  = mk(1, 0, 1, 0, 0, 0, 12'h0AA, 16'h0000, 16'h0000, 4'hA, 15, 16'h4242, 16'h4242, 1, 0, 2'b11, 16'h0000);
    vecs[10] = mk(0, 1, 1, 1, 0, 0, 12'h0BB, 16'h12CD, 16'h0000, 4'hB, 1, 16'h0000, 16'h0000, 0, 0, 2'b01, 16'hCDCD);

    clear_inputs();
    in_mem_ack = 1'b0; in_mem_rd_word = '0;
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(out_ready), 32'd1);
    chk("rst_req", 32'(out_mem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_res", 32'(out_res), 32'd0);
    #21 reset = 1'b1;
    step();

    // Table: each vector is one accepted operation followed by its completion
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      in_valid = 1'b1; in_act_load_dmem = v.load; in_act_store_dmem = v.store;
      in_act_write_res_to_reg = v.wr; in_size_byte = v.byte_sz; in_sign_ext = v.sign;
      in_addr = v.addr; in_byte_sel = v.sel; in_wr_word = v.wdata; in_res = v.res;
      in_res_reg_idx = v.idx; in_instr = 16'hA000 + 16'(i);
      step();
      clear_inputs();
      if (v.load ^ v.store) begin
        for (int c = 1; c <= v.k; c++) begin
          chk($sformatf("v%0d_req_c%0d", i, c), 32'(out_mem_req), 32'd1);
          chk($sformatf("v%0d_ready_c%0d", i, c), 32'(out_ready), 32'd0);
          chk($sformatf("v%0d_valid_c%0d", i, c), 32'(out_valid), 32'd0);
          if (c == 1) begin
            chk($sformatf("v%0d_we", i), 32'(out_mem_we), 32'(v.store));
            chk($sformatf("v%0d_addr", i), 32'(out_mem_addr), 32'(v.addr));
            chk($sformatf("v%0d_ben", i), 32'(out_mem_byte_en), 32'(v.e_ben));
            if (v.store) chk($sformatf("v%0d_wdata", i), 32'(out_mem_wr_word), 32'(v.e_wdata));
          end
          if (c == v.k) begin
            in_mem_ack = 1'b1; in_mem_rd_word = v.rd;
          end
          step();
        end
        in_mem_ack = 1'b0;
      end
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'(v.e_err));
      chk($sformatf("v%0d_wr", i), 32'(out_act_write_res_to_reg), 32'(v.e_wr));
      chk($sformatf("v%0d_req_done", i), 32'(out_mem_req), 32'd0);
      chk($sformatf("v%0d_ready_done", i), 32'(out_ready), 32'd1);
      if (!(v.load && v.store)) begin
        chk($sformatf("v%0d_res", i), 32'(out_res), 32'(v.e_res));
        chk($sformatf("v%0d_idx", i), 32'(out_res_reg_idx), 32'(v.idx));
        chk($sformatf("v%0d_instr", i), 32'(out_instr), 32'(16'hA000 + 16'(i)));
      end
    end

    // Ack with nothing outstanding produces nothing
    in_mem_ack = 1'b1; in_mem_rd_word = 16'hDEAD;
    step();
    in_mem_ack = 1'b0;
    chk("stray_ack_valid", 32'(out_valid), 32'd0);
    chk("stray_ack_req", 32'(out_mem_req), 32'd0);

    // Timeout: req held for exactly 15 cycles, then an error completion
    in_valid = 1'b1; in_act_load_dmem = 1'b1; in_act_write_res_to_reg = 1'b1;
    in_addr = 12'h055; in_res_reg_idx = 4'hC;
    step();
    clear_inputs();
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("to_req_c%0d", c), 32'(out_mem_req), 32'd1);
      chk($sformatf("to_valid_c%0d", c), 32'(out_valid), 32'd0);
      step();
    end
    chk("to_req_drop", 32'(out_mem_req), 32'd0);
    chk("to_valid", 32'(out_valid), 32'd1);
    chk("to_err", 32'(out_err), 32'd1);
    chk("to_wr", 32'(out_act_write_res_to_reg), 32'd0);
    chk("to_ready", 32'(out_ready), 32'd1);
    step();
    chk("to_valid_clr", 32'(out_valid), 32'd0);
    chk("to_err_clr", 32'(out_err), 32'd0);

    // Reset during WAIT: req drops asynchronously and the transaction vanishes
    in_valid = 1'b1; in_act_load_dmem = 1'b1; in_addr = 12'h066;
    step();
    clear_inputs();
    chk("rw_req_before", 32'(out_mem_req), 32'd1);
    step();
    reset = 1'b0;
    #1;
    chk("rw_req_async", 32'(out_mem_req), 32'd0);
    chk("rw_ready_async", 32'(out_ready), 32'd1);
    #2 reset = 1'b1;
    in_mem_ack = 1'b1; in_mem_rd_word = 16'h9999;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("rw_valid_c%0d", c), 32'(out_valid), 32'd0);
      chk($sformatf("rw_req_c%0d", c), 32'(out_mem_req), 32'd0);
    end
    in_mem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised memory stage for the swt16 pipeline, placed between execute and writeback. Accepts one operation per handshake from execute and, for loads and stores, runs a request/acknowledge transaction against a variable-latency DMEM. Supports word and byte access with byte-lane enables and sign/zero extension, and aborts with an error on DMEM timeout. Stalls execute while a DMEM transaction is outstanding; otherwise it is a one-cycle pipeline register.

## Interface
- DMEM_ADDR_WIDTH, 12, DMEM word-address width
- DMEM_WORD_WIDTH, 16, DMEM data width; power-of-two multiple of 8, at least 16
- IALU_WORD_WIDTH, 16, result width; must equal DMEM_WORD_WIDTH
- PMEM_WORD_WIDTH, 16, instruction width
- REG_IDX_WIDTH, 4, register index width
- DMEM_TIMEOUT, 15, maximum WAIT cycles before abort (1..255)
- Derived: NB = DMEM_WORD_WIDTH/8 byte lanes, BSEL_W = max(1, clog2(NB))

Ports:
- clock  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  execute presents an operation
- out_ready  output  1  stage can accept; in_valid && out_ready = accept
- in_act_load_dmem  input  1  operation is a load
- in_act_store_dmem  input  1  operation is a store
- in_act_write_res_to_reg  input  1  result is written to the register file
- in_size_byte  input  1  0 = word access, 1 = byte access
- in_sign_ext  input  1  byte load: 1 = sign-extend, 0 = zero-extend
- in_addr  input  DMEM_ADDR_WIDTH  word address
- in_byte_sel  input  BSEL_W  byte lane (byte access only)
- in_wr_word  input  DMEM_WORD_WIDTH  store data (byte store uses bits [7:0])
- in_res  input  IALU_WORD_WIDTH  execute result
- in_res_reg_idx  input  REG_IDX_WIDTH  destination register
- in_instr  input  PMEM_WORD_WIDTH  instruction (passed through for tracing)
- out_mem_req  output  1  DMEM request, held until ack or abort
- out_mem_we  output  1  1 = write
- out_mem_addr  output  DMEM_ADDR_WIDTH  DMEM word address
- out_mem_wr_word  output  DMEM_WORD_WIDTH  write data
- out_mem_byte_en  output  NB  write lane enables
- in_mem_ack  input  1  DMEM completion; read data valid the same cycle
- in_mem_rd_word  input  DMEM_WORD_WIDTH  read data
- out_valid  output  1  writeback entry valid (one cycle per operation)
- out_act_write_res_to_reg  output  1  register-file write enable
- out_res  output  IALU_WORD_WIDTH  result or load data
- out_res_reg_idx  output  REG_IDX_WIDTH  destination register
- out_instr  output  PMEM_WORD_WIDTH  instruction
- out_err  output  1  operation aborted (timeout or illegal)

## Operation
- FSM states: IDLE and WAIT. out_ready = (state == IDLE).
- Accept in IDLE, non-memory operation: the output register loads in_res, index, instr, and write flag. out_valid = 1 next cycle. State stays IDLE.
- Accept in IDLE, load or store: capture the operation into the request register and go to WAIT. out_valid = 0 next cycle.
- Accept with both load and store set: no DMEM access. Next cycle: out_valid = 1, out_err = 1, out_act_write_res_to_reg = 0.
- WAIT outputs:
  - out_mem_req = 1; out_mem_we = store; out_mem_addr = captured address.
  - Word store: all byte enables = 1; write data unchanged.
  - Byte store: byte [7:0] replicated into every lane; out_mem_byte_en is one-hot at in_byte_sel.
  - Loads: out_mem_byte_en = all ones.
- WAIT with in_mem_ack = 1:
  - Load result = read word (word load), or lane in_byte_sel extended to IALU_WORD_WIDTH per in_sign_ext (byte load).
  - Store: out_res = 0 and out_act_write_res_to_reg = 0.
  - Output register loads, out_valid = 1 next cycle, state goes to IDLE.
- Timeout: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack. When it reaches DMEM_TIMEOUT: drop req, set out_valid = 1, out_err = 1, out_act_write_res_to_reg = 0, go to IDLE.
- in_mem_ack outside WAIT is ignored.
- out_valid, out_err and out_act_write_res_to_reg clear on any cycle with no completion. Data outputs hold their last value.

## Timing
- Reset (reset low): all outputs and registers go to 0 asynchronously, state = IDLE, out_ready = 1.
- Reset asserted in WAIT: req drops immediately; the transaction is abandoned with no out_valid.
- Non-memory latency: 1 cycle, throughput 1 per cycle.
- Memory latency: accept at cycle 0, req from cycle 1, ack at cycle k ≥ 1, out_valid at k+1. Minimum 2 cycles. The next accept is possible at k+1.
- Ack at the same edge the counter reaches DMEM_TIMEOUT: ack wins, out_err = 0.
- No downstream backpressure: writeback always consumes out_valid.

## Test plan
- Reset, then non-memory ops back-to-back, in_res = 0x1234 then 0x5678, index 3 then 4 -> out_valid on two consecutive cycles with matching res/index, out_ready stays 1.
- Word store to addr 0x010, data 0xBEEF, ack after 3 cycles -> req high for 3 cycles, we = 1, byte_en = 2'b11, out_valid one cycle later, write flag 0; out_ready low throughout WAIT.
- Byte loads from a word 0x80F0: lane 1 with sign_ext -> 0xFF80; lane 0 with zero_ext -> 0x00F0; ack in the first req cycle -> out_valid 2 cycles after accept.
- Byte store of 0x00AB to lane 1 -> out_mem_wr_word = 0xABAB, byte_en = 2'b10.
- No ack for DMEM_TIMEOUT cycles -> req drops, out_valid = 1 with out_err = 1 and write flag 0; then ack coincident with timeout -> success, out_err = 0.
- Load and store both set -> no req, out_err = 1 next cycle. Reset asserted in WAIT -> req low immediately, no out_valid after release.
